// File: rtl/pytxpldser_pkg.sv
// Shared constants, state encoding and helpers for the TX payload serializer.
//   PLD_BCW / PLD_LENW : default bit-counter and byte-length widths
//   WORD_W / ADDR_W    : payload buffer word width and word-address width
//   CRC16_POLY         : CRC-CCITT polynomial
//   WHITEN_TAPS        : feedback mask of the x^7+x^4+1 whitening LFSR
package bt_bb_pkg;
  localparam int PLD_BCW  = 13;
  localparam int PLD_LENW = 10;
  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 8;
  localparam int CRC_W    = 16;

  localparam logic [CRC_W-1:0] CRC16_POLY  = 16'h1021;
  localparam logic [6:0]       WHITEN_TAPS = 7'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLD,
    S_CRC,
    S_DONE
  } state_e;

  // Galois step: bit 6 rotates into bit 0 and is also folded into bit 4.
  function automatic logic [6:0] whiten_step(input logic [6:0] l);
    return {l[5:0], l[6]} ^ (l[6] ? WHITEN_TAPS : 7'h00);
  endfunction
endpackage

// File: rtl/pytxpldser_if.sv
// Bus between the link controller / payload buffer side (master) and the
// payload serializer (slave).
//   master drives : start_p, abort_p, bit_p, pld_len, crc_en, crc_init,
//                   whiten_clk, buf_dout
//   slave drives  : buf_addr, bitcount, txbit, txbit_vld, busy, done_p
interface pytxpldser_if
  import bt_bb_pkg::*;
#(
  parameter int BCW  = PLD_BCW,
  parameter int LENW = PLD_LENW
);
  logic              start_p;
  logic              abort_p;
  logic              bit_p;
  logic [LENW-1:0]   pld_len;
  logic              crc_en;
  logic [7:0]        crc_init;
  logic [5:0]        whiten_clk;
  logic [WORD_W-1:0] buf_dout;
  logic [ADDR_W-1:0] buf_addr;
  logic [BCW-1:0]    bitcount;
  logic              txbit;
  logic              txbit_vld;
  logic              busy;
  logic              done_p;

  modport master (
    output start_p, abort_p, bit_p, pld_len, crc_en, crc_init, whiten_clk, buf_dout,
    input  buf_addr, bitcount, txbit, txbit_vld, busy, done_p
  );
  modport slave (
    input  start_p, abort_p, bit_p, pld_len, crc_en, crc_init, whiten_clk, buf_dout,
    output buf_addr, bitcount, txbit, txbit_vld, busy, done_p
  );
endinterface

// File: rtl/pytxpldser_crc16.sv
// pytxcrc16: 16-bit serial CRC-CCITT register.
//   clk, rst_n : clock, async active-low reset (register clears to 0)
//   load       : preload load_val (wins over shift_en)
//   shift_en   : advance one bit
//   din        : data bit for CRC mode
//   out_mode   : 1 = plain left shift with 0 fill, used to stream the CRC out
//   crc        : current register value, crc[15] is the next bit to send
module pytxcrc16
  import bt_bb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CRC_W-1:0] load_val,
  input  logic             shift_en,
  input  logic             din,
  input  logic             out_mode,
  output logic [CRC_W-1:0] crc
);
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = crc_q[CRC_W-1] ^ din;
    crc_d = {crc_q[CRC_W-2:0], 1'b0};
    if (!out_mode && fb) crc_d = crc_d ^ CRC16_POLY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        crc_q <= '0;
    else if (load)     crc_q <= load_val;
    else if (shift_en) crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/pytxpldser.sv
// pytxpldser: TX payload serializer. Walks a bit counter over the payload
// buffer, sends each 32-bit word LSB-first, optionally appends the 16-bit
// CRC, one bit per bit_p strobe.
//   clk_6M, rstz : 6 MHz clock, async active-low reset
//   ifc (slave)  : start/abort/bit strobes, frame setup, buffer read port,
//                  serial output with valid, busy and done pulse
// Optional build macro PYTXPLDSER_WHITEN_EN: XOR a 7-bit whitening LFSR
// (seeded {1'b1, whiten_clk}) into every emitted bit. Without it whiten_clk
// is unused and no LFSR is built.
module pytxpldser
  import bt_bb_pkg::*;
#(
  parameter int BCW  = PLD_BCW,
  parameter int LENW = PLD_LENW
) (
  input  logic          clk_6M,
  input  logic          rstz,
  pytxpldser_if.slave   ifc
);
  state_e           state_q, state_d;
  logic [BCW-1:0]   bitcount_q;
  logic [BCW-1:0]   plen_bits;
  logic [LENW-1:0]  plen_q;
  logic             crc_en_q;
  logic [3:0]       ccnt_q;
  logic             txbit_q, txbit_vld_q;
  logic             take_start, emit, raw_bit, last_pld, wbit;
  logic [CRC_W-1:0] crc;

  assign plen_bits = BCW'({plen_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    take_start = 1'b0;
    emit       = 1'b0;
    raw_bit    = 1'b0;
    last_pld   = (bitcount_q == plen_bits - BCW'(1));
    unique case (state_q)
      S_IDLE:  if (ifc.start_p) begin
                 take_start = 1'b1;
                 state_d    = S_FETCH;
               end
      // One dead cycle lets the buffer return word 0 before the first bit.
      S_FETCH: state_d = (plen_q != '0) ? S_PLD : (crc_en_q ? S_CRC : S_DONE);
      S_PLD:   if (ifc.bit_p) begin
                 emit    = 1'b1;
                 raw_bit = ifc.buf_dout[bitcount_q[4:0]];
                 if (last_pld) state_d = crc_en_q ? S_CRC : S_DONE;
               end
      S_CRC:   if (ifc.bit_p) begin
                 emit    = 1'b1;
                 raw_bit = crc[CRC_W-1];
                 if (ccnt_q == 4'hF) state_d = S_DONE;
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every other event this cycle.
    if (ifc.abort_p) begin
      state_d    = S_IDLE;
      take_start = 1'b0;
      emit       = 1'b0;
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q     <= S_IDLE;
      bitcount_q  <= '0;
      plen_q      <= '0;
      crc_en_q    <= 1'b0;
      ccnt_q      <= '0;
      txbit_q     <= 1'b0;
      txbit_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      txbit_vld_q <= emit;
      if (emit) txbit_q <= raw_bit ^ wbit;
      if (ifc.abort_p) begin
        bitcount_q <= '0;
      end else if (take_start) begin
        bitcount_q <= '0;
        ccnt_q     <= '0;
        plen_q     <= ifc.pld_len;
        crc_en_q   <= ifc.crc_en;
      end else if (emit && state_q == S_PLD) begin
        bitcount_q <= bitcount_q + BCW'(1);
      end else if (emit && state_q == S_CRC) begin
        ccnt_q <= ccnt_q + 4'd1;
      end
    end
  end

  // CRC runs over raw payload bits; in S_CRC it just shifts itself out.
  pytxcrc16 u_crc (
    .clk      (clk_6M),
    .rst_n    (rstz),
    .load     (take_start),
    .load_val ({8'h00, ifc.crc_init}),
    .shift_en (emit),
    .din      (raw_bit),
    .out_mode (state_q == S_CRC),
    .crc      (crc)
  );

`ifdef PYTXPLDSER_WHITEN_EN
  logic [6:0] lfsr_q;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)           lfsr_q <= '0;
    else if (take_start) lfsr_q <= {1'b1, ifc.whiten_clk};
    else if (emit)       lfsr_q <= whiten_step(lfsr_q);
  end

  assign wbit = lfsr_q[6];
`else
  logic unused_whiten;
  assign unused_whiten = ^ifc.whiten_clk;
  assign wbit          = 1'b0;
`endif

  // A frame longer than the bit counter can address is a caller error.
  always @(posedge clk_6M) begin
    if (take_start) assert (int'(ifc.pld_len) * 8 <= (1 << BCW));
  end

  assign ifc.buf_addr  = bitcount_q[BCW-1 -: ADDR_W];
  assign ifc.bitcount  = bitcount_q;
  assign ifc.txbit     = txbit_q;
  assign ifc.txbit_vld = txbit_vld_q;
  assign ifc.busy      = (state_q != S_IDLE);
  assign ifc.done_p    = (state_q == S_DONE);
endmodule
